// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / data) arbiter driving an asynchronous SRAM with fixed strobe timing.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data-first priority.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iread_ce,
  input  logic [31:0] irom_addr,
  output logic [31:0] rom_inst,
  output logic        ifin,
  input  logic        dread_ce,
  input  logic        dwrite_ce,
  input  logic [31:0] drom_addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  dsel,
  output logic [31:0] rom_rdata,
  output logic        dfin,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  dsel_q, dsel_d;
  logic        port_q, port_d;     // 1 = data port owns the current access
  logic [31:0] inst_q, inst_d;
  logic [31:0] rdata_q, rdata_d;
  logic        data_req;
  logic        take_data;
  logic        in_rd, in_wr;
  logic        unused_addr_bits;
`ifdef ARB_ROUND_ROBIN_EN
  logic        rr_q, rr_d;         // 1 = data port was granted last
`endif

  assign data_req = dread_ce | dwrite_ce;
  assign unused_addr_bits = ^{irom_addr[31:22], irom_addr[1:0], drom_addr[31:22], drom_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dsel_d    = dsel_q;
    port_d    = port_q;
    inst_d    = inst_q;
    rdata_d   = rdata_q;
    take_data = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (iread_ce || data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          take_data = data_req && !(iread_ce && rr_q);
          rr_d      = take_data;
`else
          take_data = data_req;
`endif
          port_d = take_data;
          cnt_d  = '0;
          if (take_data) begin
            addr_d  = drom_addr[21:2];
            wdata_d = wdata;
            dsel_d  = dsel;
            // A simultaneous read+write request is served as a write.
            state_d = dwrite_ce ? WR_SETUP : RD;
          end else begin
            addr_d  = irom_addr[21:2];
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (port_q) rdata_d = sram_dout;
          else        inst_d  = sram_dout;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        if (cnt_q == LAST_CNT) state_d = WR_HOLD;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dsel_q  <= '0;
      port_q  <= 1'b0;
      inst_q  <= '0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dsel_q  <= dsel_d;
      port_q  <= port_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Strobes decode straight from the registered state, so they are glitch-free per cycle.
  assign in_rd     = (state_q == RD);
  assign in_wr     = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
  assign sram_ce_n = !(in_rd || in_wr);
  assign sram_oe_n = !in_rd;
  assign sram_we_n = (state_q != WR_PULSE);
  assign sram_be_n = in_rd ? 4'h0 : (in_wr ? ~dsel_q : 4'hF);
  assign sram_addr = addr_q;
  assign sram_din  = wdata_q;
  assign ifin      = (state_q == DONE) && !port_q;
  assign dfin      = (state_q == DONE) && port_q;
  assign rom_inst  = inst_q;
  assign rom_rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: SRAM device model plus a transaction-level reference memory.
// Build with or without ARB_ROUND_ROBIN_EN; the grant prediction follows the same macro.
module tb_sram_arbiter;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        iread_ce, dread_ce, dwrite_ce;
  logic [31:0] irom_addr, drom_addr, wdata;
  logic [3:0]  dsel;
  logic [31:0] rom_inst, rom_rdata;
  logic        ifin, dfin;
  logic [19:0] sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  logic [31:0] dev_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_inst, exp_rdata;
  bit          model_last_data;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .iread_ce(iread_ce), .irom_addr(irom_addr), .rom_inst(rom_inst), .ifin(ifin),
    .dread_ce(dread_ce), .dwrite_ce(dwrite_ce), .drom_addr(drom_addr), .wdata(wdata), .dsel(dsel),
    .rom_rdata(rom_rdata), .dfin(dfin),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // Asynchronous SRAM device: reads while ce/oe low, byte writes while ce/we low.
  assign sram_dout = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_addr[7:0]] : 32'hDEAD0BAD;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) dev_mem[sram_addr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
  end

  // Per-cycle protocol invariants.
  always @(negedge clk) begin
    n_checks++;
    if (!sram_oe_n && !sram_we_n) begin
      n_fail++;
      $display("FAIL strobe_overlap: oe_n=%b we_n=%b, required not both 0", sram_oe_n, sram_we_n);
    end
    n_checks++;
    if (ifin && dfin) begin
      n_fail++;
      $display("FAIL dual_fin: ifin=%b dfin=%b, required at most one high", ifin, dfin);
    end
    n_checks++;
    if (sram_ce_n && (!sram_oe_n || !sram_we_n || sram_be_n !== 4'hF)) begin
      n_fail++;
      $display("FAIL idle_strobes: oe_n=%b we_n=%b be_n=%b, required 1/1/1111 while ce_n=1",
               sram_oe_n, sram_we_n, sram_be_n);
    end
  end

  function automatic logic [31:0] rand_addr(input int lo, input int hi);
    rand_addr = {10'($urandom), 12'b0, 8'($urandom_range(lo, hi)), 2'($urandom)};
  endfunction

  task automatic wait_fin(output int cyc, output bit gi, output bit gd);
    cyc = -1; gi = 0; gd = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (ifin || dfin) begin cyc = c; gi = ifin; gd = dfin; break; end
    end
  endtask

  task automatic run_txn(input bit is_fetch, input bit is_write, input bit both_ce,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                         input string name);
    int fin_c, oe_cnt, we_cnt, exp_lat, idx;
    bit got_i, got_d;
    logic [19:0] addr_seen;
    logic [3:0]  be_seen;
    logic [31:0] din_seen;
    @(negedge clk);
    idx = int'(addr[9:2]);
    if (is_fetch) begin
      iread_ce = 1; irom_addr = addr;
    end else begin
      drom_addr = addr; wdata = data; dsel = sel;
      dwrite_ce = is_write; dread_ce = !is_write || both_ce;
    end
    fin_c = -1; oe_cnt = 0; we_cnt = 0; got_i = 0; got_d = 0;
    addr_seen = 'x; be_seen = 'x; din_seen = 'x;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) begin
        irom_addr = $urandom; drom_addr = $urandom; wdata = $urandom; dsel = 4'($urandom);
      end
      if (!sram_ce_n) addr_seen = sram_addr;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) begin we_cnt++; be_seen = sram_be_n; din_seen = sram_din; end
      if (ifin || dfin) begin fin_c = c; got_i = ifin; got_d = dfin; break; end
    end
    exp_lat = is_write ? W + 4 : W + 2;
    if (is_write) begin
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    end else if (is_fetch) exp_inst = ref_mem[idx];
    else exp_rdata = ref_mem[idx];
    model_last_data = !is_fetch;

    n_checks++;
    if (fin_c !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, fin_c, exp_lat); end
    n_checks++;
    if (got_i !== is_fetch || got_d !== !is_fetch) begin
      n_fail++; $display("FAIL %s fin_port: ifin=%b dfin=%b required ifin=%b", name, got_i, got_d, is_fetch);
    end
    n_checks++;
    if (addr_seen !== addr[21:2]) begin n_fail++; $display("FAIL %s sram_addr: got %h required %h", name, addr_seen, addr[21:2]); end
    n_checks++;
    if (oe_cnt !== (is_write ? 0 : W + 1) || we_cnt !== (is_write ? W + 1 : 0)) begin
      n_fail++; $display("FAIL %s strobe_cycles: oe_low=%0d we_low=%0d", name, oe_cnt, we_cnt);
    end
    if (is_write) begin
      n_checks++;
      if (be_seen !== ~sel || din_seen !== data) begin
        n_fail++; $display("FAIL %s write_bus: be_n=%b din=%h required be_n=%b din=%h", name, be_seen, din_seen, ~sel, data);
      end
    end
    n_checks++;
    if (rom_inst !== exp_inst) begin n_fail++; $display("FAIL %s rom_inst: got %h required %h", name, rom_inst, exp_inst); end
    n_checks++;
    if (rom_rdata !== exp_rdata) begin n_fail++; $display("FAIL %s rom_rdata: got %h required %h", name, rom_rdata, exp_rdata); end
    $display("txn %s fetch=%0b write=%0b addr=%h fin_after=%0d", name, is_fetch, is_write, addr, fin_c);
    iread_ce = 0; dread_ce = 0; dwrite_ce = 0;
  endtask

  task automatic test_reset();
    rst = 0; iread_ce = 1; dread_ce = 1; dwrite_ce = 1;
    irom_addr = $urandom; drom_addr = $urandom; wdata = $urandom; dsel = 4'hF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sram_ce_n !== 1 || sram_oe_n !== 1 || sram_we_n !== 1 || sram_be_n !== 4'hF) begin
      n_fail++; $display("FAIL reset_strobes: ce_n=%b oe_n=%b we_n=%b be_n=%b", sram_ce_n, sram_oe_n, sram_we_n, sram_be_n);
    end
    n_checks++;
    if (sram_addr !== 20'h0 || sram_din !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h din=%h required 0/0", sram_addr, sram_din);
    end
    n_checks++;
    if (ifin !== 0 || dfin !== 0 || rom_inst !== 32'h0 || rom_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: ifin=%b dfin=%b inst=%h rdata=%h", ifin, dfin, rom_inst, rom_rdata);
    end
    $display("txn reset checked");
    iread_ce = 0; dread_ce = 0; dwrite_ce = 0;
    rst = 1;
    exp_inst = 0; exp_rdata = 0; model_last_data = 1;
  endtask

  task automatic test_directed();
    dev_mem[4] = 32'h3C01ABCD; ref_mem[4] = 32'h3C01ABCD;
    run_txn(1, 0, 0, 32'h00000010, 32'h0, 4'h0, "fetch_directed");
    run_txn(0, 1, 0, 32'h00000020, 32'hDEADBEEF, 4'b0011, "write_directed");
    run_txn(0, 0, 0, 32'h00000020, 32'h0, 4'h0, "readback_directed");
    run_txn(0, 1, 0, 32'h00000024, 32'h12345678, 4'b0000, "write_dsel_zero");
    run_txn(0, 0, 0, 32'h00000024, 32'h0, 4'h0, "readback_dsel_zero");
    run_txn(0, 1, 1, 32'h00000028, 32'hCAFEF00D, 4'b1111, "both_ce_write");
  endtask

  task automatic test_random(input int n);
    int kind;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 3);
      run_txn(kind == 0, kind >= 2, kind == 3, rand_addr(0, 31), $urandom, 4'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, a2;
    int cyc; bit gi, gd;
    a1 = rand_addr(0, 31); a2 = rand_addr(0, 31);
    @(negedge clk);
    iread_ce = 1; irom_addr = a1;
    wait_fin(cyc, gi, gd);
    exp_inst = ref_mem[a1[9:2]];
    n_checks++;
    if (cyc !== W + 2 || !gi || rom_inst !== exp_inst) begin
      n_fail++; $display("FAIL b2b_first: cyc=%0d ifin=%b inst=%h required %0d/1/%h", cyc, gi, rom_inst, W + 2, exp_inst);
    end
    irom_addr = a2;
    wait_fin(cyc, gi, gd);
    exp_inst = ref_mem[a2[9:2]];
    n_checks++;
    if (cyc !== W + 3 || !gi || rom_inst !== exp_inst) begin
      n_fail++; $display("FAIL b2b_second: cyc=%0d ifin=%b inst=%h required %0d/1/%h", cyc, gi, rom_inst, W + 3, exp_inst);
    end
    $display("txn back_to_back addr1=%h addr2=%h gap=%0d", a1, a2, cyc);
    iread_ce = 0;
    model_last_data = 0;
  endtask

  task automatic test_contention(input int rounds);
    logic [31:0] ai, ad;
    int cyc; bit gi, gd, exp_data;
    ai = rand_addr(0, 31); ad = rand_addr(0, 31);
    @(negedge clk);
    iread_ce = 1; irom_addr = ai; dread_ce = 1; drom_addr = ad;
`ifdef ARB_ROUND_ROBIN_EN
    exp_data = !model_last_data;
`else
    exp_data = 1;
`endif
    for (int r = 0; r < rounds; r++) begin
      wait_fin(cyc, gi, gd);
      if (exp_data) exp_rdata = ref_mem[ad[9:2]];
      else          exp_inst  = ref_mem[ai[9:2]];
      model_last_data = exp_data;
      n_checks++;
      if (cyc < 0 || gd !== exp_data || gi !== !exp_data) begin
        n_fail++; $display("FAIL contention_order round %0d: ifin=%b dfin=%b required dfin=%b", r, gi, gd, exp_data);
      end
      n_checks++;
      if (rom_inst !== exp_inst || rom_rdata !== exp_rdata) begin
        n_fail++; $display("FAIL contention_data round %0d: inst=%h rdata=%h required %h/%h", r, rom_inst, rom_rdata, exp_inst, exp_rdata);
      end
      $display("txn contention round %0d granted=%s", r, gd ? "data" : "inst");
      // Finished port drops for the IDLE sample, then re-raises while the other port is served.
      if (exp_data) dread_ce = 0; else iread_ce = 0;
      if (r < rounds - 1) begin
        @(negedge clk);
        @(negedge clk);
        if (exp_data) dread_ce = 1; else iread_ce = 1;
      end
      exp_data = !exp_data;
    end
    iread_ce = 0; dread_ce = 0;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    dwrite_ce = 1; drom_addr = {22'h0, 8'd255, 2'b00}; wdata = $urandom; dsel = 4'hF;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sram_we_n !== 0) begin n_fail++; $display("FAIL abort_in_pulse: we_n=%b required 0", sram_we_n); end
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (sram_we_n !== 1 || sram_ce_n !== 1 || dfin !== 0 || ifin !== 0) begin
      n_fail++; $display("FAIL abort_strobes: we_n=%b ce_n=%b dfin=%b ifin=%b required 1/1/0/0", sram_we_n, sram_ce_n, dfin, ifin);
    end
    @(negedge clk);
    n_checks++;
    if (dfin !== 0 || rom_inst !== 32'h0 || rom_rdata !== 32'h0) begin
      n_fail++; $display("FAIL abort_regs: dfin=%b inst=%h rdata=%h required 0/0/0", dfin, rom_inst, rom_rdata);
    end
    $display("txn reset_mid_write checked");
    dwrite_ce = 0; rst = 1;
    exp_inst = 0; exp_rdata = 0; model_last_data = 1;
    run_txn(1, 0, 0, rand_addr(0, 31), 32'h0, 4'h0, "fetch_after_abort");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      dev_mem[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_directed();
    test_random(40);
    test_back_to_back();
    test_contention(3);
    test_contention(4);
    test_random(10);
    test_reset_mid_access();
    test_contention(3);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra SRAM access cycles beyond one (legal range 0..7).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset.
REQ-004 SHALL have port iread_ce  input  1  instruction-fetch request, level, held until ifin.
REQ-005 SHALL have port irom_addr  input  32  instruction byte address.
REQ-006 SHALL have port rom_inst  output  32  fetched instruction, registered.
REQ-007 SHALL have port ifin  output  1  one-cycle instruction completion pulse.
REQ-008 SHALL have port dread_ce / dwrite_ce  input  1 each  data read / write request, level, held until dfin.
REQ-009 SHALL have port drom_addr  input  32  data byte address; wdata  input  32  write data; dsel  input  4  byte enables, active-high.
REQ-010 SHALL have port rom_rdata  output  32  data read result, registered; dfin  output  1  one-cycle data completion pulse.
REQ-011 SHALL have port sram_addr  output  20  word address; sram_din  output  32  write data to SRAM; sram_dout  input  32  read data from SRAM.
REQ-012 SHALL have port sram_ce_n / sram_oe_n / sram_we_n  output  1 each  active-low strobes; sram_be_n  output  4  active-low byte enables.

Function
REQ-013 SHALL implement states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-014 SHALL sample requests only in IDLE; a request seen in IDLE moves to RD (read/fetch) or WR_SETUP (write) next cycle.
REQ-015 SHALL latch address, wdata, dsel and granted port at grant; later input changes SHALL be ignored until DONE.
REQ-016 SHALL drive sram_addr = latched addr[21:2]; addr[1:0] and addr[31:22] ignored.
REQ-017 RD: ce_n=0, oe_n=0, we_n=1, be_n=0000, for WAIT_CYCLES+1 cycles; sram_dout captured on last RD cycle into rom_inst or rom_rdata per granted port.
REQ-018 WR_SETUP 1 cycle (ce_n=0, we_n=1, oe_n=1, sram_din and be_n=~dsel driven); WR_PULSE WAIT_CYCLES+1 cycles with we_n=0; WR_HOLD 1 cycle we_n=1, data held.
REQ-019 DONE: strobes inactive, exactly one of ifin/dfin high for one cycle, then IDLE.
REQ-020 Latency request-sampled to fin: read WAIT_CYCLES+2 cycles, write WAIT_CYCLES+4 cycles (3 and 5 at default).
REQ-021 oe_n and we_n SHALL never be low together; outside RD/WR states all strobes SHALL be 1.
REQ-022 dread_ce and dwrite_ce both high SHALL be treated as a write; single dfin.
REQ-023 A request still asserted in IDLE after DONE SHALL start a new access (back-to-back, one IDLE cycle between).
REQ-024 rom_inst/rom_rdata SHALL hold their value until the next completed read for the same port.
REQ-025 dsel=0000 write SHALL still run full sequence with be_n=1111 and complete with dfin.

Reset
REQ-026 On rising clk with rst=0: state IDLE, sram_ce_n/oe_n/we_n=1, sram_be_n=1111, sram_addr=0, sram_din=0, ifin=dfin=0, rom_inst=rom_rdata=0, round-robin flag=data.
REQ-027 Reset mid-access SHALL abandon the access with no fin pulse; first request after rst=1 is sampled in IDLE normally.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: when both ports request in IDLE, grant the port not granted last (flag updated at grant; after reset instruction wins first contest).
REQ-029 ARB_ROUND_ROBIN_EN undefined: data port has fixed priority over instruction port; flag logic absent.

Verification
REQ-030 Fetch irom_addr=0x00000010, sram_dout=0x3C01ABCD, WAIT_CYCLES=1 -> sram_addr=0x00004, oe_n low 2 cycles, ifin pulse 3 cycles after sample, rom_inst=0x3C01ABCD.
REQ-031 Write drom_addr=0x00000020, wdata=0xDEADBEEF, dsel=0011 -> sram_addr=0x00008, be_n=1100, we_n low 2 cycles, dfin 5 cycles after sample.
REQ-032 iread_ce and dread_ce rise same cycle, held through two transactions -> macro off: dfin then ifin then dfin; macro on: ifin then dfin alternating.
REQ-033 rst=0 during WR_PULSE -> next edge we_n=ce_n=1, no dfin; new fetch after rst=1 completes in 3 cycles.
REQ-034 dread_ce and dwrite_ce both high -> write sequence only, rom_rdata unchanged, one dfin.
REQ-035 Every cycle of all tests -> assert !(oe_n==0 && we_n==0) and at most one of ifin/dfin high.
